// File: rtl/uart_ctrl.sv
// uart_ctrl: CPU-facing register block for the uart.
// Buffers outgoing bytes in a small TX FIFO, sequences the uart launch
// handshake one byte at a time, captures received bytes and raises a
// level interrupt.
module uart_ctrl #(
  parameter logic [31:0] BASE_ADDR    = 32'h40000018,
  parameter int          FIFO_DEPTH   = 4,
  parameter int          BUSY_TIMEOUT = 1024
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] rdata,
  output logic        irq,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_enable,
  input  logic        uart_tx_status,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_status,
  output logic        uart_rx_enable
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_COUNT    = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(BUSY_TIMEOUT);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LAUNCH    = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  // Address decode and bus strobes
  logic sel_txd, sel_rxd, sel_con;
  logic txd_wr, con_wr, rxd_rd, con_rd;

  assign sel_txd = (addr == BASE_ADDR);
  assign sel_rxd = (addr == BASE_ADDR + 32'd4);
  assign sel_con = (addr == BASE_ADDR + 32'd8);
  assign txd_wr  = mem_write && sel_txd;
  assign con_wr  = mem_write && sel_con;
  assign rxd_rd  = mem_read && sel_rxd;
  assign con_rd  = mem_read && sel_con;

  // Only the low byte of write data is architecturally visible.
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];

  // TX FIFO
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_empty, fifo_full, push, pop;

  // TX sequencer
  logic [1:0]    state;
  logic [7:0]    hold;
  logic [TW-1:0] tmo_cnt, tmo_next;
  logic          tx_done_set, tx_err_set;

  // Control / status registers
  logic tx_irq_en, rx_irq_en, tx_done, tx_err;
  logic rx_valid, rx_overrun, rx_prev, rx_edge;
  logic [7:0] rx_byte;
  logic tx_busy;
  logic [31:0] con_value;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_COUNT);
  // The head leaves the FIFO on the IDLE->LAUNCH edge so the hold register
  // already carries the byte during the launch pulse.
  assign pop  = (state == ST_IDLE) && !fifo_empty && uart_tx_status;
  assign push = txd_wr && (!fifo_full || pop);

  assign tmo_next    = tmo_cnt + TW'(1);
  assign tx_err_set  = (state == ST_WAIT_BUSY) && uart_tx_status && (tmo_next == TIMEOUT_LIMIT);
  assign tx_done_set = (state == ST_WAIT_DONE) && uart_tx_status;

  // uart handshake: uart_tx_enable is a one-cycle launch pulse with
  // uart_tx_data valid alongside it; the uart acknowledges by dropping
  // uart_tx_status (busy) and signals completion by raising it again.
  // A launch is only issued while uart_tx_status is high (uart idle).
  assign uart_tx_enable = (state == ST_LAUNCH);
  assign uart_tx_data   = hold;
  assign uart_rx_enable = 1'b1;

  assign tx_busy   = !fifo_empty || (state != ST_IDLE);
  assign rx_edge   = uart_rx_status && !rx_prev;
  assign con_value = {24'b0, tx_err, rx_overrun, fifo_full, tx_busy,
                      rx_valid, tx_done, rx_irq_en, tx_irq_en};

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge sysclk) begin
    if (push) fifo_mem[wr_ptr] <= wdata[7:0];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge sysclk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // TX sequencer: launch, wait for busy (with timeout), wait for done
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state   <= ST_IDLE;
      hold    <= '0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            hold  <= fifo_mem[rd_ptr];
            state <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          tmo_cnt <= '0;
          state   <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          tmo_cnt <= tmo_next;
          if (!uart_tx_status) state <= ST_WAIT_DONE;
          else if (tx_err_set) state <= ST_IDLE;
        end
        default: begin
          if (uart_tx_status) state <= ST_IDLE;
        end
      endcase
    end
  end

  // CON enables and TX sticky flags; a set in the same cycle as a CON read wins
  always_ff @(posedge sysclk) begin
    if (reset) begin
      tx_irq_en <= 1'b0;
      rx_irq_en <= 1'b0;
      tx_done   <= 1'b0;
      tx_err    <= 1'b0;
    end else begin
      if (con_wr) begin
        tx_irq_en <= wdata[0];
        rx_irq_en <= wdata[1];
      end
      if (tx_done_set) tx_done <= 1'b1;
      else if (con_rd) tx_done <= 1'b0;
      if (tx_err_set)  tx_err <= 1'b1;
      else if (con_rd) tx_err <= 1'b0;
    end
  end

  // RX capture on the rising edge of uart_rx_status, with overrun tracking
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_prev    <= 1'b0;
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_prev <= uart_rx_status;
      if (rx_edge) begin
        rx_byte  <= uart_rx_data;
        rx_valid <= 1'b1;
      end else if (rxd_rd) begin
        rx_valid <= 1'b0;
      end
      if (rx_edge && rx_valid && !rxd_rd) rx_overrun <= 1'b1;
      else if (con_rd)                    rx_overrun <= 1'b0;
    end
  end

  // Registered interrupt, one cycle behind its sources
  always_ff @(posedge sysclk) begin
    if (reset) irq <= 1'b0;
    else       irq <= (tx_irq_en && tx_done) || (rx_irq_en && rx_valid);
  end

  // Combinational read mux; zero when not reading or address unmapped
  always_comb begin
    rdata = '0;
    if (mem_read) begin
      if (sel_rxd)      rdata = {24'b0, rx_byte};
      else if (sel_con) rdata = con_value;
    end
  end

endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: self-checking bench for uart_ctrl with a behavioural uart
// model, a TX byte scoreboard and bus read/write driver tasks.
module tb_uart_ctrl;

  localparam logic [31:0] BASE  = 32'h40000018;
  localparam logic [31:0] TXD_A = BASE;
  localparam logic [31:0] RXD_A = BASE + 32'd4;
  localparam logic [31:0] CON_A = BASE + 32'd8;
  localparam int DEPTH = 4;
  localparam int BT    = 1024;

  // ---------------- clock / reset ----------------
  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [31:0] addr = '0, wdata = '0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] rdata;
  logic        irq;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_enable;
  logic        uart_tx_status;
  logic [7:0]  uart_rx_data = '0;
  logic        uart_rx_status = 1'b0;
  logic        uart_rx_enable;

  uart_ctrl #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .BUSY_TIMEOUT(BT)) dut (
    .sysclk(sysclk), .reset(reset), .addr(addr), .wdata(wdata),
    .mem_read(mem_read), .mem_write(mem_write), .rdata(rdata), .irq(irq),
    .uart_tx_data(uart_tx_data), .uart_tx_enable(uart_tx_enable),
    .uart_tx_status(uart_tx_status), .uart_rx_data(uart_rx_data),
    .uart_rx_status(uart_rx_status), .uart_rx_enable(uart_rx_enable)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- uart model ----------------
  int   drop_delay = 300;
  int   busy_len   = 10400;
  bit   never_drop = 1'b0;
  bit   hold_low   = 1'b0;
  logic m_status   = 1'b1;
  int   m_phase    = 0;
  int   m_cnt      = 0;

  assign uart_tx_status = hold_low ? 1'b0 : m_status;

  always @(negedge sysclk) begin
    case (m_phase)
      0: if (uart_tx_enable && !never_drop) begin m_phase = 1; m_cnt = 0; end
      1: begin
        m_cnt++;
        if (m_cnt >= drop_delay) begin m_status = 1'b0; m_phase = 2; m_cnt = 0; end
      end
      default: begin
        m_cnt++;
        if (m_cnt >= busy_len) begin m_status = 1'b1; m_phase = 0; end
      end
    endcase
  end

  // ---------------- scoreboard / TX monitor ----------------
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  int launch_cnt      = 0;
  int last_launch_cyc = 0;
  bit prev_en         = 1'b0;

  always @(negedge sysclk) begin
    if (prev_en) check("tx_en_width", {31'b0, uart_tx_enable}, 32'd0);
    prev_en = uart_tx_enable;
    if (uart_tx_enable === 1'b1) begin
      launch_cnt++;
      last_launch_cyc = cyc;
      check("tx_q_nonempty", {31'b0, (exp_q.size() > 0)}, 32'd1);
      if (exp_q.size() > 0) begin
        exp_b = exp_q.pop_front();
        check("tx_byte", {24'b0, uart_tx_data}, {24'b0, exp_b});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge sysclk); addr = a; wdata = d; mem_write = 1'b1;
    @(negedge sysclk); mem_write = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge sysclk); addr = a; mem_read = 1'b1;
    #1 d = rdata;
    @(negedge sysclk); mem_read = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] b, input bit expect_sent);
    if (expect_sent) exp_q.push_back(b);
    bus_write(TXD_A, {24'b0, b});
  endtask

  task automatic wait_launches(input int target, input int budget, input string tag);
    int n = 0;
    while (launch_cnt < target && n < budget) begin @(negedge sysclk); #1; n++; end
    check(tag, launch_cnt, target);
  endtask

  task automatic wait_idle(input int budget);
    logic [31:0] v;
    int n = 0;
    do begin bus_read(CON_A, v); n++; end while (v[4] && n < budget);
    check("tx_idle", {31'b0, v[4]}, 32'd0);
  endtask

  task automatic wait_status(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (uart_tx_status !== lvl && n < budget) begin @(negedge sysclk); #1; n++; end
    check(tag, {31'b0, uart_tx_status}, {31'b0, lvl});
  endtask

  // Hold a CON read until bit b is seen; one more strobed edge clears stickies
  task automatic poll_con_bit(input int b, input int budget, input string tag, output int seen);
    int n = 0;
    @(negedge sysclk); addr = CON_A; mem_read = 1'b1;
    #1;
    while (!rdata[b] && n < budget) begin @(negedge sysclk); #1; n++; end
    check(tag, {31'b0, rdata[b]}, 32'd1);
    seen = cyc;
    @(negedge sysclk); mem_read = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    @(negedge sysclk); uart_rx_data = d; uart_rx_status = 1'b1;
    repeat (3) @(negedge sysclk);
    uart_rx_status = 1'b0;
    repeat (3) @(negedge sysclk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] v;
    int base, c1, c2, seen;

    // Reset state
    repeat (3) @(negedge sysclk);
    reset = 1'b0;
    bus_read(CON_A, v);
    check("con_reset", v, 32'h0);
    check("tx_en_reset", {31'b0, uart_tx_enable}, 32'd0);
    check("tx_data_reset", {24'b0, uart_tx_data}, 32'd0);
    check("irq_reset", {31'b0, irq}, 32'd0);
    check("rx_enable", {31'b0, uart_rx_enable}, 32'd1);

    // Two bytes through a slow uart
    drop_delay = 300; busy_len = 10400;
    push_tx(8'h55, 1'b1);
    push_tx(8'hA3, 1'b1);
    wait_launches(2, 12000, "two_launches");
    bus_read(CON_A, v);
    check("con_done_busy", v, 32'h14);
    bus_read(CON_A, v);
    check("con_done_cleared", v, 32'h10);
    wait_idle(7000);

    // FIFO full and dropped push
    drop_delay = 5; busy_len = 20; hold_low = 1'b1;
    base = launch_cnt;
    for (int i = 0; i < 3; i++) push_tx(8'($urandom_range(0, 255)), 1'b1);
    bus_read(CON_A, v);
    check("con_fifo3", v, 32'h10);
    push_tx(8'($urandom_range(0, 255)), 1'b1);
    bus_read(CON_A, v);
    check("con_full", v, 32'h30);
    @(negedge sysclk); addr = CON_A; mem_read = 1'b0;
    #1 check("rdata_noread", rdata, 32'h0);
    push_tx(8'hEE, 1'b0);
    bus_read(CON_A, v);
    check("con_full_after_drop", v, 32'h30);
    hold_low = 1'b0;
    wait_launches(base + DEPTH, 400, "full_launches");
    wait_idle(200);
    repeat (50) @(negedge sysclk);
    check("tx_drop_count", launch_cnt, base + DEPTH);
    check("tx_q_drained", exp_q.size(), 32'd0);

    // Busy timeout: tx_err rises BT cycles after the LAUNCH cycle ends,
    // visible one cycle later, and the next queued byte launches.
    never_drop = 1'b1;
    base = launch_cnt;
    push_tx(8'hA1, 1'b1);
    push_tx(8'hA2, 1'b1);
    wait_launches(base + 1, 20, "tmo_launch1");
    c1 = last_launch_cyc;
    poll_con_bit(7, 2 * BT, "tmo_err1", seen);
    check("tmo_latency1", seen - c1, BT + 1);
    wait_launches(base + 2, 20, "tmo_launch2");
    c2 = last_launch_cyc;
    poll_con_bit(7, 2 * BT, "tmo_err2", seen);
    check("tmo_latency2", seen - c2, BT + 1);
    never_drop = 1'b0;

    // RX overrun and interrupt
    bus_write(CON_A, 32'h2);
    bus_read(CON_A, v);
    check("con_pre_rx", v, 32'h02);
    rx_pulse(8'h3C);
    rx_pulse(8'h7E);
    check("irq_rx_high", {31'b0, irq}, 32'd1);
    bus_read(BASE + 32'd12, v);
    check("unmapped_read", v, 32'h0);
    bus_read(CON_A, v);
    check("con_overrun", v, 32'h4A);
    check("irq_still_high", {31'b0, irq}, 32'd1);
    bus_read(RXD_A, v);
    check("rxd_byte", v, 32'h7E);
    check("irq_lag", {31'b0, irq}, 32'd1);
    @(negedge sysclk);
    check("irq_low", {31'b0, irq}, 32'd0);
    bus_read(CON_A, v);
    check("con_after_rx", v, 32'h02);

    // Reset during WAIT_DONE with bytes queued
    drop_delay = 5; busy_len = 200;
    base = launch_cnt;
    push_tx(8'h11, 1'b1);
    push_tx(8'h22, 1'b0);
    push_tx(8'h33, 1'b0);
    wait_launches(base + 1, 20, "rst_launch");
    wait_status(1'b0, 50, "rst_busy");
    repeat (5) @(negedge sysclk);
    reset = 1'b1;
    repeat (2) @(negedge sysclk);
    reset = 1'b0;
    bus_read(CON_A, v);
    check("con_after_reset", v, 32'h0);
    check("irq_after_reset", {31'b0, irq}, 32'd0);
    wait_status(1'b1, 400, "rst_uart_idle");
    repeat (10) @(negedge sysclk);
    check("no_launch_after_reset", launch_cnt, base + 1);
    push_tx(8'h5A, 1'b1);
    wait_launches(base + 2, 20, "launch_after_reset");
    wait_idle(200);
    check("final_q_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
